// File: rtl/vx_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// vx_mem_arb_pkg
//   Shared helpers for the N-to-1 memory request arbiter.
//   - sel_bits():      number of channel-index bits appended to the tag
//                      (0 when there is only one channel).
//   - tag_out_width(): width of the merged tag {tag_in, channel index}.
//   - VX_MEM_REQ_T():  builds the packed request word {rw, byteen, addr,
//                      data, tag} from width parameters. A package typedef
//                      cannot depend on a module's parameters, so the struct
//                      shape lives in a macro and each user instantiates it
//                      with its own widths.
// ---------------------------------------------------------------------------
`ifndef VX_MEM_REQ_T
`define VX_MEM_REQ_T(DW, BW, AW, TW) \
    struct packed { \
        logic            rw; \
        logic [(BW)-1:0] byteen; \
        logic [(AW)-1:0] addr; \
        logic [(DW)-1:0] data; \
        logic [(TW)-1:0] tag; \
    }
`endif

package vx_mem_arb_pkg;

    function automatic int sel_bits(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 0;
    endfunction

    function automatic int tag_out_width(input int num_reqs, input int tag_in_width);
        return tag_in_width + sel_bits(num_reqs);
    endfunction

endpackage

// File: rtl/vx_mem_req_skid_buf.sv
// ---------------------------------------------------------------------------
// vx_mem_req_skid_buf
//   Generic 2-entry elastic pipe register. The main entry drives the output;
//   the skid entry catches one word accepted while the main entry is full
//   and stalled. enq_ready is a pure register output (skid entry empty), so
//   there is no combinational path from deq_ready back to the producer.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     enq_valid/enq_data    incoming word, transferred when enq_ready=1
//     enq_ready             skid entry empty
//     deq_valid/deq_data    main entry contents (data zero after reset)
//     deq_ready             downstream accept
// ---------------------------------------------------------------------------
module vx_mem_req_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enq_valid,
    input  logic [WIDTH-1:0] enq_data,
    output logic             enq_ready,
    output logic             deq_valid,
    output logic [WIDTH-1:0] deq_data,
    input  logic             deq_ready
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             enq_fire;
    logic             deq_fire;

    assign enq_ready = ~skid_valid;
    assign enq_fire  = enq_valid & ~skid_valid;
    assign deq_fire  = main_valid & deq_ready;

    assign deq_valid = main_valid;
    assign deq_data  = main_data;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
        end else if (skid_valid) begin
            // Skid is older than anything upstream: it refills main first.
            // enq_ready is low, so no new word can arrive this cycle.
            if (deq_fire) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (enq_fire) begin
            if (!main_valid || deq_fire) begin
                main_data  <= enq_data;
                main_valid <= 1'b1;
            end else begin
                skid_valid <= 1'b1;
            end
        end else if (deq_fire) begin
            main_valid <= 1'b0;
        end
    end

    // NOTE: skid_data is qualified by skid_valid, so it carries no reset;
    // only control state and the externally visible payload are reset.
    always_ff @(posedge clk) begin
        if (enq_fire && main_valid && !deq_fire) begin
            skid_data <= enq_data;
        end
    end

endmodule

// File: rtl/vx_mem_req_arb.sv
// ---------------------------------------------------------------------------
// vx_mem_req_arb
//   N-to-1 arbiter for memory request bundles. One request is granted per
//   cycle (round-robin or fixed lowest-index priority), tagged with its
//   source channel index in the tag LSBs, and registered through a 2-entry
//   elastic stage so the accepted request appears on the output next cycle.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     req_*_in            packed per-channel request bundles, ch i in slice i
//     req_ready_in        per-channel accept, at most one bit high
//     req_*_out           merged request, tag = {tag_in, channel index}
//     req_ready_out       downstream accept
// ---------------------------------------------------------------------------
module vx_mem_req_arb
    import vx_mem_arb_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 8,
    parameter int DATA_SIZE    = DATA_WIDTH / 8,
    parameter int ARB_RR       = 1,
    localparam int TAG_OUT_WIDTH = tag_out_width(NUM_REQS, TAG_IN_WIDTH)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,
    output logic                             req_valid_out,
    output logic                             req_rw_out,
    output logic [DATA_SIZE-1:0]             req_byteen_out,
    output logic [ADDR_WIDTH-1:0]            req_addr_out,
    output logic [DATA_WIDTH-1:0]            req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
    input  logic                             req_ready_out
);

    localparam int SEL_BITS = sel_bits(NUM_REQS);
    // Pointer/index need at least one bit even when there is nothing to select.
    localparam int PTR_W    = (SEL_BITS > 0) ? SEL_BITS : 1;

    typedef `VX_MEM_REQ_T(DATA_WIDTH, DATA_SIZE, ADDR_WIDTH, TAG_OUT_WIDTH) mem_req_t;
    localparam int REQ_W = $bits(mem_req_t);

    logic                    can_accept;
    logic                    grant_valid;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        rr_ptr;

    logic                    sel_rw;
    logic [DATA_SIZE-1:0]    sel_byteen;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [TAG_IN_WIDTH-1:0] sel_tag_in;
    logic [TAG_OUT_WIDTH-1:0] sel_tag;

    mem_req_t                sel_req;
    mem_req_t                out_req;

    // ------------------------------------------------------------------
    // Grant: first valid channel walking upward from the search start,
    // wrapping at NUM_REQS. Fixed priority always starts the walk at 0.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        int c;
        grant_valid = 1'b0;
        grant_idx   = '0;
        c           = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            c = (ARB_RR != 0) ? int'(rr_ptr) + k : k;
            if (c >= NUM_REQS) begin
                c = c - NUM_REQS;
            end
            if (!grant_valid && req_valid_in[c]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(c);
            end
        end
    end

    // Ready is withheld during reset even though the (reset) skid entry
    // reports space, so masters never see an accept while reset_n=0.
    always_comb begin
        req_ready_in = '0;
        if (grant_valid && can_accept && reset_n) begin
            req_ready_in[grant_idx] = 1'b1;
        end
    end

    // Payload mux for the granted channel.
    always_comb begin
        int gi;
        gi         = int'(grant_idx);
        sel_rw     = req_rw_in[gi];
        sel_byteen = req_byteen_in[gi*DATA_SIZE +: DATA_SIZE];
        sel_addr   = req_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        sel_tag_in = req_tag_in[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH];
    end

    // Channel index rides in the tag LSBs so the response path can demux.
    if (SEL_BITS > 0) begin : g_tag_idx
        assign sel_tag = {sel_tag_in, grant_idx};
    end else begin : g_tag_pass
        assign sel_tag = sel_tag_in;
    end

    assign sel_req = mem_req_t'({sel_rw, sel_byteen, sel_addr, sel_data, sel_tag});

    // Round-robin pointer: next search starts just past the last winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if ((ARB_RR != 0) && grant_valid && can_accept) begin
            if (int'(grant_idx) == NUM_REQS - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + PTR_W'(1);
            end
        end
    end

    vx_mem_req_skid_buf #(
        .WIDTH (REQ_W)
    ) u_out_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .enq_valid (grant_valid),
        .enq_data  (sel_req),
        .enq_ready (can_accept),
        .deq_valid (req_valid_out),
        .deq_data  (out_req),
        .deq_ready (req_ready_out)
    );

    assign req_rw_out     = out_req.rw;
    assign req_byteen_out = out_req.byteen;
    assign req_addr_out   = out_req.addr;
    assign req_data_out   = out_req.data;
    assign req_tag_out    = out_req.tag;

endmodule

// File: tb/tb_vx_mem_req_arb.sv
module tb_vx_mem_req_arb;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int BW  = DW / 8;
    localparam int TOW = TW + 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- main DUT: 4 channels, round-robin ----------------
    logic [N-1:0]    ch_valid = '0;
    logic [N-1:0]    ch_rw = '0;
    logic [BW-1:0]   ch_byteen [N];
    logic [AW-1:0]   ch_addr   [N];
    logic [DW-1:0]   ch_data   [N];
    logic [TW-1:0]   ch_tag    [N];

    logic [N-1:0]    rw_in;
    logic [N*BW-1:0] byteen_in;
    logic [N*AW-1:0] addr_in;
    logic [N*DW-1:0] data_in;
    logic [N*TW-1:0] tag_in;
    logic [N-1:0]    ready_in;
    logic            valid_out, rw_out;
    logic [BW-1:0]   byteen_out;
    logic [AW-1:0]   addr_out;
    logic [DW-1:0]   data_out;
    logic [TOW-1:0]  tag_out;
    logic            ready_out = 1'b1;

    always_comb begin
        rw_in     = ch_rw;
        byteen_in = '0;
        addr_in   = '0;
        data_in   = '0;
        tag_in    = '0;
        for (int i = 0; i < N; i++) begin
            byteen_in[i*BW +: BW] = ch_byteen[i];
            addr_in[i*AW +: AW]   = ch_addr[i];
            data_in[i*DW +: DW]   = ch_data[i];
            tag_in[i*TW +: TW]    = ch_tag[i];
        end
    end

    vx_mem_req_arb #(
        .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .ARB_RR(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_in(ch_valid), .req_rw_in(rw_in), .req_byteen_in(byteen_in),
        .req_addr_in(addr_in), .req_data_in(data_in), .req_tag_in(tag_in),
        .req_ready_in(ready_in),
        .req_valid_out(valid_out), .req_rw_out(rw_out), .req_byteen_out(byteen_out),
        .req_addr_out(addr_out), .req_data_out(data_out), .req_tag_out(tag_out),
        .req_ready_out(ready_out)
    );

    // ---------------- fixed-priority DUT ----------------
    logic [N-1:0]    fx_valid = '0;
    logic [N-1:0]    fx_ready_in;
    logic            fx_valid_out, fx_rw_out;
    logic [BW-1:0]   fx_byteen_out;
    logic [AW-1:0]   fx_addr_out;
    logic [DW-1:0]   fx_data_out;
    logic [TOW-1:0]  fx_tag_out;
    logic            fx_ready_out = 1'b1;
    logic [N*TW-1:0] fx_tag_in = {8'h33, 8'h22, 8'h11, 8'h00};

    vx_mem_req_arb #(
        .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .ARB_RR(0)
    ) dut_fx (
        .clk(clk), .reset_n(reset_n),
        .req_valid_in(fx_valid), .req_rw_in('0), .req_byteen_in('1),
        .req_addr_in('0), .req_data_in('0), .req_tag_in(fx_tag_in),
        .req_ready_in(fx_ready_in),
        .req_valid_out(fx_valid_out), .req_rw_out(fx_rw_out), .req_byteen_out(fx_byteen_out),
        .req_addr_out(fx_addr_out), .req_data_out(fx_data_out), .req_tag_out(fx_tag_out),
        .req_ready_out(fx_ready_out)
    );

    // ---------------- single-channel DUT ----------------
    logic        one_valid = 1'b0;
    logic [7:0]  one_tag = 8'h00;
    logic [0:0]  one_ready_in;
    logic        one_valid_out, one_rw_out;
    logic [3:0]  one_byteen_out;
    logic [AW-1:0] one_addr_out;
    logic [31:0] one_data_out;
    logic [7:0]  one_tag_out;

    vx_mem_req_arb #(
        .NUM_REQS(1), .DATA_WIDTH(32), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(8), .ARB_RR(1)
    ) dut_one (
        .clk(clk), .reset_n(reset_n),
        .req_valid_in(one_valid), .req_rw_in(1'b0), .req_byteen_in(4'hF),
        .req_addr_in(AW'(32'h40)), .req_data_in(32'hDEAD_BEEF), .req_tag_in(one_tag),
        .req_ready_in(one_ready_in),
        .req_valid_out(one_valid_out), .req_rw_out(one_rw_out), .req_byteen_out(one_byteen_out),
        .req_addr_out(one_addr_out), .req_data_out(one_data_out), .req_tag_out(one_tag_out),
        .req_ready_out(1'b1)
    );

    // ---------------- behavioural model of the main DUT ----------------
    // Everything accepted but not yet consumed downstream sits in a FIFO
    // queue; the stage can take a new request while fewer than two are held.
    typedef struct {
        logic           rw;
        logic [BW-1:0]  byteen;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [TOW-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    int   last_grant = -1;

    always @(negedge clk) begin
        int         g;
        exp_t       e;
        logic [N-1:0] exp_rdy;
        if (!reset_n) begin
            q.delete();
            m_ptr = 0;
            last_grant = -1;
            check("rst_valid_out", 64'(valid_out), 64'd0);
            check("rst_ready_in", 64'(ready_in), 64'd0);
            check("rst_addr_out", 64'(addr_out), 64'd0);
            check("rst_data_out", 64'(data_out), 64'd0);
            check("rst_tag_out", 64'(tag_out), 64'd0);
            check("rst_byteen_rw", 64'({byteen_out, rw_out}), 64'd0);
        end else begin
            g = -1;
            if (q.size() < 2) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && ch_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("ready_in", 64'(ready_in), 64'(exp_rdy));
            check("valid_out", 64'(valid_out), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check("out_rw", 64'(rw_out), 64'(q[0].rw));
                check("out_byteen", 64'(byteen_out), 64'(q[0].byteen));
                check("out_addr", 64'(addr_out), 64'(q[0].addr));
                check("out_data", data_out, q[0].data);
                check("out_tag", 64'(tag_out), 64'(q[0].tag));
            end
            if (q.size() > 0 && ready_out) void'(q.pop_front());
            if (g >= 0) begin
                e.rw     = ch_rw[g];
                e.byteen = ch_byteen[g];
                e.addr   = ch_addr[g];
                e.data   = ch_data[g];
                e.tag    = TOW'(ch_tag[g]) * TOW'(N) + TOW'(g);
                q.push_back(e);
                m_ptr = (g + 1) % N;
            end
            last_grant = g;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic new_req(input int i);
        ch_valid[i]  = 1'b1;
        ch_rw[i]     = 1'($urandom);
        ch_byteen[i] = BW'($urandom);
        ch_addr[i]   = AW'($urandom);
        ch_data[i]   = {$urandom, $urandom};
        ch_tag[i]    = TW'($urandom);
    endtask

    // Advance one clock; the channel accepted at that edge drops valid and,
    // if refill is set, immediately presents a fresh request.
    task automatic step(input bit refill);
        @(posedge clk);
        #1;
        if (last_grant >= 0) begin
            ch_valid[last_grant] = 1'b0;
            if (refill) new_req(last_grant);
        end
    endtask

    logic [3:0] rr_exp [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    logic [7:0] one_tags [3] = '{8'hC3, 8'hC4, 8'hC5};

    initial begin
        int acc;
        for (int i = 0; i < N; i++) begin
            ch_byteen[i] = '0; ch_addr[i] = '0; ch_data[i] = '0; ch_tag[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Light traffic, then stall downstream so the buffer is full.
        for (int c = 0; c < 20; c++) begin
            ready_out = ($urandom % 3) != 0;
            for (int i = 0; i < N; i++) if (!ch_valid[i] && ($urandom % 2)) new_req(i);
            step(0);
        end
        ready_out = 1'b0;
        for (int i = 0; i < N; i++) if (!ch_valid[i]) new_req(i);
        repeat (3) step(1);

        // Reset mid-burst: outputs drop immediately, not at the next edge.
        reset_n = 1'b0;
        #1;
        check("async_rst_valid_out", 64'(valid_out), 64'd0);
        check("async_rst_ready_in", 64'(ready_in), 64'd0);
        check("async_rst_addr_out", 64'(addr_out), 64'd0);
        step(0);
        step(0);
        for (int i = 0; i < N; i++) new_req(i);
        ready_out = 1'b1;
        reset_n = 1'b1;

        // Round-robin with every channel always valid: 0,1,2,3,0,1.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rr_order", 64'(ready_in), 64'(rr_exp[c]));
            if (c > 0) check("rr_no_bubble", 64'(valid_out), 64'd1);
            step(1);
        end
        repeat (6) step(0);

        // Single request on ch2.
        new_req(2);
        ch_addr[2] = AW'(32'h100);
        ch_tag[2] = 8'h5A;
        ch_rw[2] = 1'b1;
        ch_byteen[2] = '1;
        @(negedge clk);
        check("single_grant", 64'(ready_in), 64'h4);
        step(0);
        @(negedge clk);
        check("single_valid", 64'(valid_out), 64'd1);
        check("single_addr", 64'(addr_out), 64'h100);
        check("single_tag", 64'(tag_out), 64'h16A);
        check("single_rw", 64'(rw_out), 64'd1);
        check("single_byteen", 64'(byteen_out), 64'hFF);
        step(0);

        // Backpressure: ch0 streams while downstream stalls for 3 cycles.
        ready_out = 1'b0;
        new_req(0);
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready", 64'(ready_in[0]), 64'(c < 2));
            acc += int'(ready_in[0]);
            step(1);
        end
        check("bp_accepted", 64'(acc), 64'd2);
        ready_out = 1'b1;
        repeat (6) step(0);

        // Randomised traffic, alternating light and heavy backpressure.
        for (int c = 0; c < 3000; c++) begin
            if ((c / 200) % 2 == 0) ready_out = ($urandom % 4) != 0;
            else ready_out = ($urandom % 4) == 0;
            for (int i = 0; i < N; i++) if (!ch_valid[i] && ($urandom % 3) == 0) new_req(i);
            step(0);
        end
        ready_out = 1'b1;
        repeat (10) step(0);

        // Fixed priority: ch1 always wins over ch3 until it drops.
        fx_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("fx_grant_ch1", 64'(fx_ready_in), 64'h2);
            @(posedge clk);
            #1;
        end
        fx_valid = 4'b1000;
        @(negedge clk);
        check("fx_grant_ch3", 64'(fx_ready_in), 64'h8);
        check("fx_tag_ch1", 64'(fx_tag_out), 64'h45);
        @(posedge clk);
        #1 fx_valid = 4'b0000;
        @(negedge clk);
        check("fx_tag_ch3", 64'(fx_tag_out), 64'hCF);

        // Single channel: tag passes unmodified, 1-cycle latency, 1 req/cycle.
        one_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) one_tag = one_tags[c];
            else one_valid = 1'b0;
            @(negedge clk);
            if (c < 3) check("one_ready", 64'(one_ready_in), 64'd1);
            if (c > 0) begin
                check("one_valid_out", 64'(one_valid_out), 64'd1);
                check("one_tag_out", 64'(one_tag_out), 64'(one_tags[c-1]));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("one_idle", 64'(one_valid_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
